// File: rtl/serial_sum_deserializer.sv
// Collects an LSB-first serial sum stream plus the final carry into a parallel word.
// All outputs are registered; one result_valid pulse is issued per completed frame.
module serial_sum_deserializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sum_in,
  input  logic             carry_in,
  output logic [WIDTH:0]   result,
  output logic             result_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  shreg_q;
  logic [WIDTH-1:0]  frame;

  // Shift register with the current bit merged in; counter is 0 in idle.
  always_comb begin
    frame        = shreg_q;
    frame[cnt_q] = sum_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shreg_q      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            shreg_q <= frame;
            if (WIDTH == 1) begin
              result       <= {carry_in, frame};
              result_valid <= 1'b1;
            end else begin
              cnt_q   <= CntW'(1);
              busy    <= 1'b1;
              state_q <= StShift;
            end
          end
        end
        StShift: begin
          shreg_q <= frame;
          overrun <= start;
          if (cnt_q == LastIdx) begin
            // carry_in is the adder's carry-out of the final sum bit
            result       <= {carry_in, frame};
            result_valid <= 1'b1;
            busy         <= 1'b0;
            cnt_q        <= '0;
            state_q      <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sum_deserializer.sv
// Directed bench for serial_sum_deserializer at WIDTH=8 and WIDTH=1.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_serial_sum_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, sum8, carry8;
  logic [8:0] result8;
  logic       valid8, busy8, overrun8;
  logic       start1, sum1, carry1;
  logic [1:0] result1;
  logic       valid1, busy1, overrun1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_sum_deserializer #(.WIDTH(8)) dut8 (
    .clk          (clk),
    .rst          (rst),
    .start        (start8),
    .sum_in       (sum8),
    .carry_in     (carry8),
    .result       (result8),
    .result_valid (valid8),
    .busy         (busy8),
    .overrun      (overrun8)
  );

  serial_sum_deserializer #(.WIDTH(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .start        (start1),
    .sum_in       (sum1),
    .carry_in     (carry1),
    .result       (result1),
    .result_valid (valid1),
    .busy         (busy1),
    .overrun      (overrun1)
  );

  task automatic test_reset();
    rst = 1'b1;
    start8 = 1'b0; sum8 = 1'b1; carry8 = 1'b1;
    start1 = 1'b0; sum1 = 1'b1; carry1 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({result8, valid8, busy8, overrun8} !== 12'h0) begin
      errors++;
      $display("FAIL reset_w8: got result=%h valid=%b busy=%b overrun=%b, want all 0",
               result8, valid8, busy8, overrun8);
    end
    checks++;
    if ({result1, valid1, busy1, overrun1} !== 5'h0) begin
      errors++;
      $display("FAIL reset_w1: got result=%b valid=%b busy=%b overrun=%b, want all 0",
               result1, valid1, busy1, overrun1);
    end
  endtask

  // Drives one frame starting at the next edge; ovr_at>=0 adds a stray start on that bit.
  // carry8 is driven inverted on non-final bits to show it is only sampled at the end.
  task automatic send_frame8(input logic [7:0] d, input logic c, input int ovr_at,
                             input string name);
    for (int i = 0; i < 8; i++) begin
      start8 = (i == 0) || (i == ovr_at);
      sum8   = d[i];
      carry8 = (i == 7) ? c : ~c;
      @(negedge clk);
      checks++;
      if (busy8 !== (i < 7)) begin
        errors++;
        $display("FAIL %s_busy_bit%0d: got %b, want %b", name, i, busy8, (i < 7));
      end
      checks++;
      if (valid8 !== (i == 7)) begin
        errors++;
        $display("FAIL %s_valid_bit%0d: got %b, want %b", name, i, valid8, (i == 7));
      end
      checks++;
      if (overrun8 !== (i == ovr_at && i > 0)) begin
        errors++;
        $display("FAIL %s_overrun_bit%0d: got %b, want %b", name, i, overrun8,
                 (i == ovr_at && i > 0));
      end
    end
    checks++;
    if (result8 !== {c, d}) begin
      errors++;
      $display("FAIL %s_result: got %h, want %h", name, result8, {c, d});
    end
    start8 = 1'b0;
    sum8   = 1'b0;
    carry8 = 1'b0;
  endtask

  task automatic idle8(input int n, input logic [8:0] held, input string name);
    for (int i = 0; i < n; i++) begin
      sum8   = i[0];
      carry8 = ~i[0];
      @(negedge clk);
      checks++;
      if ({valid8, busy8, overrun8} !== 3'b000 || result8 !== held) begin
        errors++;
        $display("FAIL %s_idle%0d: got valid=%b busy=%b overrun=%b result=%h, want 0 0 0 %h",
                 name, i, valid8, busy8, overrun8, result8, held);
      end
    end
    sum8 = 1'b0;
    carry8 = 1'b0;
  endtask

  task automatic test_basic();
    send_frame8(8'h96, 1'b0, -1, "basic96");
    idle8(3, 9'h096, "basic96");
  endtask

  task automatic test_carry();
    // 0xFF + 0x01: all-zero sum with carry out
    send_frame8(8'h00, 1'b1, -1, "carry100");
    idle8(2, 9'h100, "carry100");
  endtask

  task automatic test_overrun();
    send_frame8(8'hA5, 1'b0, 4, "ovr_mid");
    idle8(2, 9'h0A5, "ovr_mid");
    send_frame8(8'h3C, 1'b1, 7, "ovr_last");
    idle8(2, 9'h13C, "ovr_last");
  endtask

  task automatic test_back_to_back();
    send_frame8(8'h12, 1'b0, -1, "b2b_first");
    send_frame8(8'h34, 1'b0, -1, "b2b_second");
    idle8(2, 9'h034, "b2b");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      start8 = (i == 0);
      sum8   = d[i];
      @(negedge clk);
    end
    start8 = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({result8, valid8, busy8} !== 11'h0) begin
      errors++;
      $display("FAIL rst_mid: got result=%h valid=%b busy=%b, want 0 0 0",
               result8, valid8, busy8);
    end
    idle8(8, 9'h000, "rst_mid");
    send_frame8(8'h7E, 1'b0, -1, "after_rst");
  endtask

  task automatic test_width1();
    start1 = 1'b1; sum1 = 1'b1; carry1 = 1'b1;
    @(negedge clk);
    checks++;
    if ({result1, valid1, busy1} !== 4'b1110) begin
      errors++;
      $display("FAIL w1_first: got result=%b valid=%b busy=%b, want 11 1 0",
               result1, valid1, busy1);
    end
    start1 = 1'b1; sum1 = 1'b0; carry1 = 1'b1;
    @(negedge clk);
    checks++;
    if ({result1, valid1, busy1, overrun1} !== 5'b10100) begin
      errors++;
      $display("FAIL w1_second: got result=%b valid=%b busy=%b overrun=%b, want 10 1 0 0",
               result1, valid1, busy1, overrun1);
    end
    start1 = 1'b0; sum1 = 1'b1; carry1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({result1, valid1, busy1, overrun1} !== 5'b10000) begin
      errors++;
      $display("FAIL w1_idle: got result=%b valid=%b busy=%b overrun=%b, want 10 0 0 0",
               result1, valid1, busy1, overrun1);
    end
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; sum8 = 1'b0; carry8 = 1'b0;
    start1 = 1'b0; sum1 = 1'b0; carry1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_carry();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
